v_lv0_egress: RTL

Downstream consumer of the level-0 notify bus of the list engine `v`. It buffers top-of-list change notifications in a small FIFO and coalesces back-to-back updates for the same product. It presents the notifications to a back-pressured consumer on a valid/ready interface. It also accounts for drops on overflow and discards notifications while the list tables are initialising.

---
 rtl/v_pkg.sv | 12 +
 rtl/v_lv0_fifo.sv | 54 +++++
 rtl/v_lv0_egress.sv | 87 ++++++++
 3 files changed

// File: rtl/v_pkg.sv
// v_pkg: shared types and sizes for the list engine and its level-0 egress
package v_pkg;
   typedef logic [7:0]  id_t;
   typedef logic [15:0] key_t;
   typedef logic [15:0] size_t;
   typedef struct packed {
      id_t   prod_id;
      key_t  key;
      size_t size;
   } lv0_ntf_t;
   localparam int V_LV0_EGRESS_DEPTH = 8;
endpackage

// File: rtl/v_lv0_fifo.sv
// v_lv0_fifo: circular notification storage with a tail-overwrite port for coalescing
module v_lv0_fifo
   import v_pkg::*;
#(
   parameter int DEPTH = V_LV0_EGRESS_DEPTH,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic          i_ovw,
   input  lv0_ntf_t      i_din,
   input  lv0_ntf_t      i_ovw_din,
   output lv0_ntf_t      o_head,
   output lv0_ntf_t      o_tail,
   output logic [CW-1:0] o_cnt
);
   lv0_ntf_t      mem_q [DEPTH];
   lv0_ntf_t      mem_d [DEPTH];
   logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d, tail_idx;
   logic [CW-1:0] cnt_q, cnt_d;

   // next storage contents, pointers and occupancy
   always_comb begin
      mem_d    = mem_q;
      tail_idx = wptr_q - AW'(1);
      wptr_d   = i_push ? wptr_q + AW'(1) : wptr_q;
      rptr_d   = i_pop ? rptr_q + AW'(1) : rptr_q;
      cnt_d    = cnt_q + CW'(i_push) - CW'(i_pop);
      if (i_push) mem_d[wptr_q] = i_din;
      if (i_ovw) mem_d[tail_idx] = i_ovw_din;
   end

   // storage and pointer registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q  <= '{default: '0};
         rptr_q <= '0;
         wptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         mem_q  <= mem_d;
         rptr_q <= rptr_d;
         wptr_q <= wptr_d;
         cnt_q  <= cnt_d;
      end
   end

   assign o_head = mem_q[rptr_q];
   assign o_tail = mem_q[tail_idx];
   assign o_cnt  = cnt_q;
endmodule

// File: rtl/v_lv0_egress.sv
// v_lv0_egress: buffers, coalesces and presents level-0 top-of-list notifications
module v_lv0_egress
   import v_pkg::*;
#(
   parameter int DEPTH  = V_LV0_EGRESS_DEPTH,
   parameter int DROP_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_lv0_vld_r,
   input  id_t               i_lv0_prod_id_r,
   input  key_t              i_lv0_key_r,
   input  size_t             i_lv0_size_r,
   input  logic              i_busy_r,
   output logic              o_ntf_vld_r,
   input  logic              i_ntf_rdy,
   output id_t               o_ntf_prod_id_r,
   output key_t              o_ntf_key_r,
   output size_t             o_ntf_size_r,
   output logic [DROP_W-1:0] o_drop_cnt_r,
   output logic              o_ovf_r
);
   localparam int CW = $clog2(DEPTH) + 1;

   lv0_ntf_t          in_beat, head, tail, ntf_q, ntf_d;
   logic [CW-1:0]     cnt;
   logic              acc, load, empty, full, pop, coal, byp, push, drop;
   logic              ntf_vld_q, ntf_vld_d, ovf_q, ovf_d;
   logic [DROP_W-1:0] drop_q, drop_d;

   // classify the incoming beat: coalesce into tail, bypass, push or drop
   always_comb begin
      in_beat = '{prod_id: i_lv0_prod_id_r, key: i_lv0_key_r, size: i_lv0_size_r};
      acc     = i_lv0_vld_r && !i_busy_r;
      load    = !ntf_vld_q || i_ntf_rdy;
      empty   = cnt == '0;
      full    = cnt == CW'(DEPTH);
      pop     = load && !empty;
      coal    = acc && (cnt >= CW'(2) || (cnt == CW'(1) && !pop)) && tail.prod_id == in_beat.prod_id;
      byp     = acc && load && empty;
      push    = acc && !coal && !byp && (!full || pop);
      drop    = acc && !coal && !byp && full && !pop;
   end

   // output register source selection and drop accounting
   always_comb begin
      ntf_vld_d = load ? (pop || byp) : ntf_vld_q;
      ntf_d     = pop ? head : byp ? in_beat : ntf_q;
      drop_d    = (drop && !(&drop_q)) ? drop_q + DROP_W'(1) : drop_q;
      ovf_d     = ovf_q || drop;
   end

   // output, drop counter and overflow registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ntf_vld_q <= 1'b0;
         ntf_q     <= '0;
         drop_q    <= '0;
         ovf_q     <= 1'b0;
      end else begin
         ntf_vld_q <= ntf_vld_d;
         ntf_q     <= ntf_d;
         drop_q    <= drop_d;
         ovf_q     <= ovf_d;
      end
   end

   v_lv0_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .i_push   (push),
      .i_pop    (pop),
      .i_ovw    (coal),
      .i_din    (in_beat),
      .i_ovw_din(in_beat),
      .o_head   (head),
      .o_tail   (tail),
      .o_cnt    (cnt)
   );

   assign o_ntf_vld_r     = ntf_vld_q;
   assign o_ntf_prod_id_r = ntf_q.prod_id;
   assign o_ntf_key_r     = ntf_q.key;
   assign o_ntf_size_r    = ntf_q.size;
   assign o_drop_cnt_r    = drop_q;
   assign o_ovf_r         = ovf_q;
endmodule
